// File: rtl/cpu_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_pkg
//   Shared types and constants for the 6502 bus arbiter slice.
//   - arb_state_e : arbiter FSM states (CPU, HALT, DMA, REL)
//   - REQ0/REQ1   : requester index constants used to pick grant bits
//   - addr_t/data_t/req_t : bus field types shared by the interface and RTL
//   - idx_to_onehot : converts a requester index into a one-hot grant
// ---------------------------------------------------------------------------
package cpu_bus_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int REQ0    = 0;
  localparam int REQ1    = 1;

  // Burst counter needs 9 bits so a cap of 256 is reachable without wrap.
  localparam int BURST_W = 9;
  localparam int GUARD_W = 4;

  typedef logic [15:0]        addr_t;
  typedef logic [7:0]         data_t;
  typedef logic [NUM_REQ-1:0] req_t;

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_HALT = 2'd1,
    ST_DMA  = 2'd2,
    ST_REL  = 2'd3
  } arb_state_e;

  function automatic req_t idx_to_onehot(input logic idx);
    return idx ? req_t'(2'b10) : req_t'(2'b01);
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_if
//   Groups the CPU side, both DMA requesters and the shared memory bus.
//   Inputs to the arbiter : cpu_rw, cpu_addr, cpu_dout, dma_req, dma_last,
//                           dma_we, dma_addr0/1, dma_dout0/1
//   Outputs from arbiter  : ready, dma_gnt, bus_addr, bus_we, bus_dout
//   Modports:
//     master - the arbiter itself (it owns the memory bus)
//     slave  - the CPU core / requesters / memory side
// ---------------------------------------------------------------------------
interface cpu_bus_arbiter_if;
  import cpu_bus_arbiter_pkg::*;

  logic  cpu_rw;
  addr_t cpu_addr;
  data_t cpu_dout;
  req_t  dma_req;
  req_t  dma_last;
  req_t  dma_we;
  addr_t dma_addr0;
  addr_t dma_addr1;
  data_t dma_dout0;
  data_t dma_dout1;

  logic  ready;
  req_t  dma_gnt;
  addr_t bus_addr;
  logic  bus_we;
  data_t bus_dout;

  modport master (
    input  cpu_rw, cpu_addr, cpu_dout,
    input  dma_req, dma_last, dma_we,
    input  dma_addr0, dma_addr1, dma_dout0, dma_dout1,
    output ready, dma_gnt, bus_addr, bus_we, bus_dout
  );

  modport slave (
    output cpu_rw, cpu_addr, cpu_dout,
    output dma_req, dma_last, dma_we,
    output dma_addr0, dma_addr1, dma_dout0, dma_dout1,
    input  ready, dma_gnt, bus_addr, bus_we, bus_dout
  );

endinterface

// File: rtl/cpu_bus_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_rr_pick2
//   Two-way round-robin selector.
//   req_i  : request levels of requester 0 and 1
//   last_i : index of the requester served most recently
//   win_o  : one-hot winner, 00 when nobody requests
//   A lone requester always wins; when both request, the one that was not
//   served last gets the bus.
// ---------------------------------------------------------------------------
module cpu_bus_arbiter_rr_pick2
  import cpu_bus_arbiter_pkg::*;
(
  input  req_t req_i,
  input  logic last_i,
  output req_t win_o
);

  // Pure combinational pick; the caller registers the result as the grant.
  always_comb begin
    win_o = '0;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = idx_to_onehot(~last_i);
      default: win_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
//   Shares the 6502 core's single memory bus between the CPU and two DMA
//   requesters. The core is stalled through its ready input, which on NMOS
//   parts only halts read cycles, so the bus is never taken during a write.
//
//   Parameters:
//     MAX_BURST : max consecutive DMA transfers per grant (1..256)
//     MIN_CPU   : min cycles ready stays high after a release (1..15)
//   Ports:
//     clk   : system clock, all state on posedge
//     reset : asynchronous, active-high
//     arb   : cpu_bus_arbiter_if.master (CPU, requesters and memory bus)
//
//   Flow: CPU -> HALT (ready low, winner picked) -> DMA (one transfer per
//   cycle while dma_gnt is high) -> REL (guard loaded) -> CPU.
// ---------------------------------------------------------------------------
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 256,
  parameter int MIN_CPU   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu_bus_arbiter_if.master       arb
);

  localparam logic [BURST_W-1:0] BURST_CAP  = BURST_W'(MAX_BURST);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(MIN_CPU - 1);

  arb_state_e          state_q, state_d;
  logic                ready_q, ready_d;
  req_t                gnt_q,   gnt_d;
  logic                rr_q,    rr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;

  req_t                win;
  logic                gnt_idx;
  logic                dma_exit;

  cpu_bus_arbiter_rr_pick2 u_pick (
    .req_i  (arb.dma_req),
    .last_i (rr_q),
    .win_o  (win)
  );

  // Index of the requester currently holding the bus; only meaningful
  // while in DMA, where gnt_q is guaranteed one-hot.
  assign gnt_idx = gnt_q[REQ1];

  // A burst ends on the requester's own last flag, on it withdrawing its
  // request, or when the burst cap is hit. Any combination is one exit.
  assign dma_exit = arb.dma_last[gnt_idx]
                  | ~arb.dma_req[gnt_idx]
                  | (burst_q == BURST_CAP);

  // State register. Reset drops the grant and releases the CPU at once,
  // so an interrupted requester has to start its transfer over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CPU;
      ready_q <= 1'b1;
      gnt_q   <= '0;
      rr_q    <= 1'b0;
      burst_q <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      guard_q <= guard_d;
    end
  end

  // Next-state logic. ready and dma_gnt are computed one cycle ahead so the
  // outputs come straight from flops. Leaving DMA raises ready on the same
  // edge that drops the grant, so the CPU resumes right after the last
  // transfer; REL then loads the guard that keeps the CPU running for a
  // minimum stretch before the next halt.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    guard_d = guard_q;

    case (state_q)
      ST_CPU: begin
        ready_d = 1'b1;
        if (guard_q != '0) begin
          guard_d = guard_q - GUARD_W'(1);
        end else if ((|arb.dma_req) && arb.cpu_rw) begin
          state_d = ST_HALT;
          ready_d = 1'b0;
        end
      end

      // The CPU repeats its stalled read this cycle, so the bus stays
      // with the CPU while the winner is chosen.
      ST_HALT: begin
        if (win == '0) begin
          state_d = ST_REL;
          ready_d = 1'b1;
        end else begin
          state_d = ST_DMA;
          gnt_d   = win;
          burst_d = BURST_W'(1);
        end
      end

      // The other requester is not considered here; it keeps its request
      // level up and wins the next HALT.
      ST_DMA: begin
        if (dma_exit) begin
          state_d = ST_REL;
          gnt_d   = '0;
          rr_d    = gnt_idx;
          ready_d = 1'b1;
        end else begin
          burst_d = burst_q + BURST_W'(1);
        end
      end

      ST_REL: begin
        state_d = ST_CPU;
        ready_d = 1'b1;
        burst_d = '0;
        guard_d = GUARD_INIT;
      end

      default: begin
        state_d = ST_CPU;
        ready_d = 1'b1;
        gnt_d   = '0;
      end
    endcase
  end

  // Bus steering is selected only by the registered grant, so the mux
  // select never glitches with request or CPU timing.
  always_comb begin
    arb.bus_addr = arb.cpu_addr;
    arb.bus_we   = ~arb.cpu_rw;
    arb.bus_dout = arb.cpu_dout;
    if (gnt_q[REQ0]) begin
      arb.bus_addr = arb.dma_addr0;
      arb.bus_we   = arb.dma_we[REQ0];
      arb.bus_dout = arb.dma_dout0;
    end else if (gnt_q[REQ1]) begin
      arb.bus_addr = arb.dma_addr1;
      arb.bus_we   = arb.dma_we[REQ1];
      arb.bus_dout = arb.dma_dout1;
    end
  end

  assign arb.ready   = ready_q;
  assign arb.dma_gnt = gnt_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//   Self-checking bench for cpu_bus_arbiter (MAX_BURST=4, MIN_CPU=2).
//   Each step drives one cycle of CPU/requester inputs and pushes the
//   ready/grant values expected after the next clock edge; the entry is
//   popped and compared (with the implied bus mux contents) #1 after it.
// ---------------------------------------------------------------------------
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  typedef struct packed {
    logic ready;
    req_t gnt;
  } exp_t;

  logic  clk;
  logic  reset;
  exp_t  expQueue[$];
  int    checkCount = 0;
  int    errorCount = 0;
  string phase = "init";

  cpu_bus_arbiter_if bif();

  cpu_bus_arbiter #(
    .MAX_BURST (4),
    .MIN_CPU   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bif)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s/%s observed %h expected %h at %0t",
               phase, tag, observed, expected, $time);
    end
  endtask

  // Compares ready, grant and the bus mux against an expected entry; the
  // bus values follow from the expected grant and the driven inputs.
  task automatic compareBus(input exp_t e);
    logic [15:0] expAddr;
    logic        expWe;
    logic [7:0]  expDout;
    expAddr = bif.cpu_addr;
    expWe   = ~bif.cpu_rw;
    expDout = bif.cpu_dout;
    if (e.gnt == 2'b01) begin
      expAddr = bif.dma_addr0;
      expWe   = bif.dma_we[0];
      expDout = bif.dma_dout0;
    end else if (e.gnt == 2'b10) begin
      expAddr = bif.dma_addr1;
      expWe   = bif.dma_we[1];
      expDout = bif.dma_dout1;
    end
    checkOutput("ready",    16'(bif.ready),    16'(e.ready));
    checkOutput("dma_gnt",  16'(bif.dma_gnt),  16'(e.gnt));
    checkOutput("bus_addr", bif.bus_addr,      expAddr);
    checkOutput("bus_we",   16'(bif.bus_we),   16'(expWe));
    checkOutput("bus_dout", 16'(bif.bus_dout), 16'(expDout));
  endtask

  // Drives one cycle and scoreboards the outputs seen after its edge.
  task automatic applyStimulus(input logic rw, input req_t req, input req_t last,
                               input logic expReady, input req_t expGnt);
    exp_t e;
    bif.cpu_rw    = rw;
    bif.dma_req   = req;
    bif.dma_last  = last;
    bif.cpu_addr  = 16'($urandom());
    bif.cpu_dout  = 8'($urandom());
    bif.dma_addr0 = 16'($urandom());
    bif.dma_addr1 = 16'($urandom());
    bif.dma_dout0 = 8'($urandom());
    bif.dma_dout1 = 8'($urandom());
    bif.dma_we    = 2'($urandom());
    e.ready = expReady;
    e.gnt   = expGnt;
    expQueue.push_back(e);
    @(posedge clk);
    #1;
    e = expQueue.pop_front();
    compareBus(e);
  endtask

  // Step code layout: {cpu_rw, dma_req[1:0], dma_last[1:0], ready, gnt[1:0]}
  task automatic step(input logic [7:0] code);
    applyStimulus(code[7], code[6:5], code[4:3], code[2], code[1:0]);
  endtask

  initial begin
    exp_t e;
    reset         = 1'b1;
    bif.cpu_rw    = 1'b1;
    bif.cpu_addr  = 16'h1234;
    bif.cpu_dout  = 8'h5A;
    bif.dma_req   = '0;
    bif.dma_last  = '0;
    bif.dma_we    = '0;
    bif.dma_addr0 = 16'hA000;
    bif.dma_addr1 = 16'hB000;
    bif.dma_dout0 = 8'h11;
    bif.dma_dout1 = 8'h22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    phase = "reset";
    e.ready = 1'b1;
    e.gnt   = 2'b00;
    compareBus(e);

    // Both requesting with pointer 0: requester 1 first, then 0 after guard.
    phase = "round_robin";
    step(8'b1_11_00_0_00);
    step(8'b1_11_00_0_10);
    step(8'b1_11_10_1_00);
    step(8'b1_11_00_1_00);
    step(8'b1_11_00_1_00);
    step(8'b1_11_00_0_00);
    step(8'b1_11_00_0_01);
    step(8'b1_11_01_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Requester 0: four transfers, last flagged on the fourth.
    phase = "burst_last";
    step(8'b1_01_00_0_00);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_01_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Requester 1: last and request drop together after two transfers.
    phase = "last_and_drop";
    step(8'b1_10_00_0_00);
    step(8'b1_10_00_0_10);
    step(8'b1_10_00_0_10);
    step(8'b1_00_10_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // No halt during CPU writes; halt follows the first read.
    phase = "write_hold";
    step(8'b0_10_00_1_00);
    step(8'b0_10_00_1_00);
    step(8'b0_10_00_1_00);
    step(8'b1_10_00_0_00);
    step(8'b1_10_00_0_10);
    step(8'b1_10_10_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Request withdrawn while the CPU is still writing: nothing happens.
    phase = "withdraw_on_write";
    step(8'b0_01_00_1_00);
    step(8'b0_01_00_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Burst cap of 4 with no last: forced release, guard, re-halt.
    phase = "burst_cap";
    step(8'b1_01_00_0_00);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_1_00);
    step(8'b1_01_00_1_00);
    step(8'b1_01_00_1_00);
    step(8'b1_01_00_0_00);
    step(8'b1_01_00_0_01);
    step(8'b1_01_01_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Requester 1 arrives mid-burst: held, then served next.
    phase = "held_arrival";
    step(8'b1_01_00_0_00);
    step(8'b1_01_00_0_01);
    step(8'b1_11_00_0_01);
    step(8'b1_11_01_1_00);
    step(8'b1_10_00_1_00);
    step(8'b1_10_00_1_00);
    step(8'b1_10_00_0_00);
    step(8'b1_10_00_0_10);
    step(8'b1_10_10_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Request dropped during HALT: no grant, ready back next cycle.
    phase = "drop_in_halt";
    step(8'b1_01_00_0_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Request withdrawn mid-burst ends the burst.
    phase = "drop_mid_burst";
    step(8'b1_10_00_0_00);
    step(8'b1_10_00_0_10);
    step(8'b1_10_00_0_10);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    // Asynchronous reset in the middle of a requester 0 burst.
    phase = "async_reset";
    step(8'b1_01_00_0_00);
    step(8'b1_01_00_0_01);
    step(8'b1_01_00_0_01);
    #2;
    reset = 1'b1;
    #1;
    e.ready = 1'b1;
    e.gnt   = 2'b00;
    compareBus(e);
    @(posedge clk);
    #1;
    compareBus(e);
    @(negedge clk);
    reset = 1'b0;

    // Pointer is back at 0 after reset: requester 1 wins a tie again.
    phase = "post_reset_rr";
    step(8'b1_11_00_0_00);
    step(8'b1_11_00_0_10);
    step(8'b1_11_10_1_00);
    step(8'b1_00_00_1_00);
    step(8'b1_00_00_1_00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
